// File: rtl/eq_lock_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : eq_lock_monitor
//  Purpose  : Watches the eq/ne/ceq/cne flags of an upstream 4-bit comparator
//             and declares lock after LOCK_CNT consecutive valid matches.
//             Lock is dropped after UNLOCK_CNT consecutive valid mismatches.
//             Any self-contradictory flag set parks the FSM in FAULT until
//             clr_err. Saturating totals of matches and mismatches are kept.
//  Revision : 1.0  initial release
// ============================================================================
module eq_lock_monitor #(
  parameter int LOCK_CNT   = 4,   // consecutive matches to lock (1..15)
  parameter int UNLOCK_CNT = 2    // consecutive mismatches to unlock (1..15)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       eq,
  input  logic       ne,
  input  logic       ceq,
  input  logic       cne,
  input  logic       clr_err,
  output logic [1:0] state,
  output logic       locked,
  output logic       lock_pulse,
  output logic       unlock_pulse,
  output logic       err,
  output logic [7:0] match_cnt,
  output logic [7:0] mismatch_cnt
);

  // FSM encoding is visible on the state port, so it is fixed here.
  localparam logic [1:0] c_SEARCH = 2'b00;
  localparam logic [1:0] c_CHECK  = 2'b01;
  localparam logic [1:0] c_LOCKED = 2'b10;
  localparam logic [1:0] c_FAULT  = 2'b11;

  // Run lengths never exceed 15, so 4-bit thresholds are sufficient.
  localparam logic [3:0] c_LOCK_TH   = 4'(LOCK_CNT);
  localparam logic [3:0] c_UNLOCK_TH = 4'(UNLOCK_CNT);
  localparam logic [7:0] c_CNT_MAX   = 8'hFF;

  // --------------------------------------------------------------------------
  // Sample classification
  // --------------------------------------------------------------------------
  logic w_inconsistent;
  logic w_bad;
  logic w_match;
  logic w_mismatch;

  // A well-formed flag set has eq/ne complementary, ceq/cne complementary,
  // and eq agreeing with ceq (4-bit inputs never carry X/Z upstream).
  assign w_inconsistent = (eq == ne) || (ceq == cne) || (eq != ceq);
  assign w_bad          = in_valid &&  w_inconsistent;
  assign w_match        = in_valid && !w_inconsistent &&  eq;
  assign w_mismatch     = in_valid && !w_inconsistent && !eq;

  // --------------------------------------------------------------------------
  // State and run-length registers
  // --------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_run;
  logic [3:0] w_run_nxt;
  logic [3:0] r_miss;
  logic [3:0] w_miss_nxt;

  // State register: FSM state plus the match/miss run lengths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_SEARCH;
      r_run   <= 4'd0;
      r_miss  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_miss  <= w_miss_nxt;
    end
  end

  // Next-state logic: an inconsistent sample overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_miss_nxt  = r_miss;
    if (w_bad) begin
      w_state_nxt = c_FAULT;
      w_run_nxt   = 4'd0;
      w_miss_nxt  = 4'd0;
    end else begin
      case (r_state)
        c_SEARCH: begin
          if (w_match) begin
            if (c_LOCK_TH == 4'd1) begin
              w_state_nxt = c_LOCKED;
              w_run_nxt   = 4'd0;
            end else begin
              w_state_nxt = c_CHECK;
              w_run_nxt   = 4'd1;
            end
          end
        end
        c_CHECK: begin
          if (w_match) begin
            if ((r_run + 4'd1) == c_LOCK_TH) begin
              w_state_nxt = c_LOCKED;
              w_run_nxt   = 4'd0;
            end else begin
              w_run_nxt   = r_run + 4'd1;
            end
          end else if (w_mismatch) begin
            w_state_nxt = c_SEARCH;
            w_run_nxt   = 4'd0;
          end
        end
        c_LOCKED: begin
          if (w_mismatch) begin
            if ((r_miss + 4'd1) == c_UNLOCK_TH) begin
              w_state_nxt = c_SEARCH;
              w_miss_nxt  = 4'd0;
            end else begin
              w_miss_nxt  = r_miss + 4'd1;
            end
          end else if (w_match) begin
            w_miss_nxt = 4'd0;
          end
        end
        c_FAULT: begin
          // clr_err is honoured here only; a valid bad sample was caught above.
          if (clr_err) begin
            w_state_nxt = c_SEARCH;
          end
        end
        default: begin
          w_state_nxt = c_SEARCH;
          w_run_nxt   = 4'd0;
          w_miss_nxt  = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  logic       r_locked;
  logic       r_lock_pulse;
  logic       r_unlock_pulse;
  logic       r_err;
  logic [7:0] r_match_cnt;
  logic [7:0] r_mismatch_cnt;

  logic       w_locked_nxt;
  logic       w_lock_pulse_nxt;
  logic       w_unlock_pulse_nxt;
  logic       w_err_nxt;
  logic [7:0] w_match_cnt_nxt;
  logic [7:0] w_mismatch_cnt_nxt;

  // Output logic: derive next-cycle outputs from the transition being taken.
  always_comb begin
    w_locked_nxt       = (w_state_nxt == c_LOCKED);
    // FAULT exits only to SEARCH, so entering LOCKED is always a real lock.
    w_lock_pulse_nxt   = (r_state != c_LOCKED) && (w_state_nxt == c_LOCKED);
    // LOCKED -> FAULT deliberately gives no unlock event.
    w_unlock_pulse_nxt = (r_state == c_LOCKED) && (w_state_nxt == c_SEARCH);
    w_err_nxt          = (w_state_nxt == c_FAULT);
    w_match_cnt_nxt    = r_match_cnt;
    w_mismatch_cnt_nxt = r_mismatch_cnt;
    if (w_match && (r_match_cnt != c_CNT_MAX)) begin
      w_match_cnt_nxt = r_match_cnt + 8'd1;
    end
    if (w_mismatch && (r_mismatch_cnt != c_CNT_MAX)) begin
      w_mismatch_cnt_nxt = r_mismatch_cnt + 8'd1;
    end
  end

  // Output register: every output has exactly one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked       <= 1'b0;
      r_lock_pulse   <= 1'b0;
      r_unlock_pulse <= 1'b0;
      r_err          <= 1'b0;
      r_match_cnt    <= 8'd0;
      r_mismatch_cnt <= 8'd0;
    end else begin
      r_locked       <= w_locked_nxt;
      r_lock_pulse   <= w_lock_pulse_nxt;
      r_unlock_pulse <= w_unlock_pulse_nxt;
      r_err          <= w_err_nxt;
      r_match_cnt    <= w_match_cnt_nxt;
      r_mismatch_cnt <= w_mismatch_cnt_nxt;
    end
  end

  assign state        = r_state;
  assign locked       = r_locked;
  assign lock_pulse   = r_lock_pulse;
  assign unlock_pulse = r_unlock_pulse;
  assign err          = r_err;
  assign match_cnt    = r_match_cnt;
  assign mismatch_cnt = r_mismatch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eq_lock_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eq_lock_monitor
//  Purpose  : Self-checking bench for eq_lock_monitor. Each applied sample
//             steps a small behavioural model whose expected outputs are
//             queued and compared once the DUT has registered the sample.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eq_lock_monitor;

  localparam int L = 4;
  localparam int U = 2;

  // Stimulus encoding: {in_valid, eq, ne, ceq, cne, clr_err}
  localparam logic [5:0] c_M  = 6'b110100;  // valid match
  localparam logic [5:0] c_X  = 6'b101010;  // valid mismatch
  localparam logic [5:0] c_I  = 6'b000000;  // idle
  localparam logic [5:0] c_B  = 6'b111100;  // valid inconsistent (eq=ne=1)
  localparam logic [5:0] c_C  = 6'b000001;  // clr_err, not valid
  localparam logic [5:0] c_BC = 6'b111101;  // inconsistent together with clr_err
  localparam logic [5:0] c_MC = 6'b110101;  // match with clr_err

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, eq = 1'b0, ne = 1'b0, ceq = 1'b0, cne = 1'b0, clr_err = 1'b0;
  logic [1:0] state;
  logic       locked, lock_pulse, unlock_pulse, err;
  logic [7:0] match_cnt, mismatch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected packed outputs: {state, locked, lock_pulse, unlock_pulse, err, match_cnt, mismatch_cnt}
  logic [21:0] sb[$];

  // Behavioural model state
  logic [1:0] m_state;
  int         m_run, m_miss, m_mc, m_mmc;
  logic       m_lp, m_ulp;

  eq_lock_monitor #(.LOCK_CNT(L), .UNLOCK_CNT(U)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .eq(eq), .ne(ne),
    .ceq(ceq), .cne(cne), .clr_err(clr_err), .state(state), .locked(locked),
    .lock_pulse(lock_pulse), .unlock_pulse(unlock_pulse), .err(err),
    .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [21:0] outs();
    return {state, locked, lock_pulse, unlock_pulse, err, match_cnt, mismatch_cnt};
  endfunction

  task automatic model_reset();
    m_state = 2'b00; m_run = 0; m_miss = 0; m_mc = 0; m_mmc = 0; m_lp = 0; m_ulp = 0;
    sb.delete();
  endtask

  // Drive one sample, advance the model, queue its expectation, then wait
  // until the DUT has registered it (sampling 1 ns after the edge).
  task automatic step(input logic [5:0] s);
    logic v, e, n, ce, cn, c, bad;
    {v, e, n, ce, cn, c} = s;
    in_valid = v; eq = e; ne = n; ceq = ce; cne = cn; clr_err = c;
    bad   = v && ((e == n) || (ce == cn) || (e != ce));
    m_lp  = 1'b0;
    m_ulp = 1'b0;
    if (v && !bad) begin
      if (e) m_mc  = (m_mc  < 255) ? m_mc  + 1 : 255;
      else   m_mmc = (m_mmc < 255) ? m_mmc + 1 : 255;
    end
    if (bad) begin
      m_state = 2'b11; m_run = 0; m_miss = 0;
    end else if (m_state == 2'b11) begin
      if (c) m_state = 2'b00;
    end else if (v && (m_state == 2'b00 || m_state == 2'b01)) begin
      if (e) begin
        m_run++;
        if (m_run == L) begin m_state = 2'b10; m_lp = 1'b1; m_run = 0; end
        else m_state = 2'b01;
      end else begin
        m_run = 0; m_state = 2'b00;
      end
    end else if (v && m_state == 2'b10) begin
      if (!e) begin
        m_miss++;
        if (m_miss == U) begin m_state = 2'b00; m_ulp = 1'b1; m_miss = 0; end
      end else begin
        m_miss = 0;
      end
    end
    sb.push_back({m_state, (m_state == 2'b10), m_lp, m_ulp, (m_state == 2'b11),
                  8'(m_mc), 8'(m_mmc)});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; eq = 0; ne = 0; ceq = 0; cne = 0; clr_err = 0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [21:0] got, exp;
    do_reset();
    n_checks++;
    if (outs() !== 22'd0) begin
      n_fail++; $display("FAIL reset_values got=%h exp=%h", outs(), 22'd0);
    end
    step(c_I);
    got = outs(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_idle got=%h exp=%h", got, exp); end
  endtask

  task automatic test_lock_acquire();
    logic [1:0]  st_exp[4];
    logic [21:0] got, exp;
    st_exp = '{2'b01, 2'b01, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(c_M);
      got = outs(); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL lock_acq[%0d] got=%h exp=%h", i, got, exp); end
      n_checks++;
      if (state !== st_exp[i] || lock_pulse !== (i == 3)) begin
        n_fail++;
        $display("FAIL lock_acq_state[%0d] got state=%b lp=%b exp state=%b lp=%b", i, state, lock_pulse, st_exp[i], (i == 3));
      end
    end
    n_checks++;
    if (match_cnt !== 8'd4 || locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_acq_cnt got mc=%0d locked=%b exp mc=4 locked=1", match_cnt, locked);
    end
    step(c_I);
    got = outs(); exp = sb.pop_front(); n_checks++;
    if (got !== exp || lock_pulse !== 1'b0) begin
      n_fail++; $display("FAIL lock_pulse_width got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_broken_run();
    logic [5:0]  seq[8];
    logic [21:0] got, exp;
    seq = '{c_M, c_M, c_M, c_X, c_M, c_M, c_M, c_M};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i]);
      got = outs(); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL broken_run[%0d] got=%h exp=%h", i, got, exp); end
      if (i == 6) begin
        n_checks++;
        if (state === 2'b10) begin n_fail++; $display("FAIL broken_run_early got state=%b exp not 10", state); end
      end
    end
    n_checks++;
    if (state !== 2'b10 || mismatch_cnt !== 8'd1 || match_cnt !== 8'd7) begin
      n_fail++;
      $display("FAIL broken_run_end got state=%b mmc=%0d mc=%0d exp state=10 mmc=1 mc=7", state, mismatch_cnt, match_cnt);
    end
  endtask

  // Continues from the LOCKED state left by test_broken_run.
  task automatic test_lock_loss();
    logic [5:0]  seq[4];
    logic [21:0] got, exp;
    seq = '{c_X, c_M, c_X, c_X};
    foreach (seq[i]) begin
      step(seq[i]);
      got = outs(); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL lock_loss[%0d] got=%h exp=%h", i, got, exp); end
      n_checks++;
      if (i < 3 && (locked !== 1'b1 || unlock_pulse !== 1'b0)) begin
        n_fail++; $display("FAIL lock_loss_hold[%0d] got locked=%b ulp=%b exp 1 0", i, locked, unlock_pulse);
      end else if (i == 3 && (state !== 2'b00 || unlock_pulse !== 1'b1 || locked !== 1'b0)) begin
        n_fail++; $display("FAIL lock_loss_drop got state=%b ulp=%b exp state=00 ulp=1", state, unlock_pulse);
      end
    end
    step(c_I);
    got = outs(); exp = sb.pop_front(); n_checks++;
    if (got !== exp || unlock_pulse !== 1'b0) begin
      n_fail++; $display("FAIL unlock_pulse_width got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_fault();
    logic [5:0]  seq[11];
    logic [21:0] got, exp;
    // lock, fault, clear; fault, clr with bad sample, match in FAULT, clear with match
    seq = '{c_M, c_M, c_M, c_M, c_B, c_C, c_B, c_BC, c_M, c_MC, c_C};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i]);
      got = outs(); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL fault_seq[%0d] got=%h exp=%h", i, got, exp); end
      if (i == 4) begin
        n_checks++;
        if (state !== 2'b11 || err !== 1'b1 || locked !== 1'b0 || unlock_pulse !== 1'b0 ||
            match_cnt !== 8'd4 || mismatch_cnt !== 8'd0) begin
          n_fail++;
          $display("FAIL fault_entry got st=%b err=%b lk=%b ulp=%b mc=%0d exp st=11 err=1 lk=0 ulp=0 mc=4",
                   state, err, locked, unlock_pulse, match_cnt);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (state !== 2'b00 || err !== 1'b0) begin
          n_fail++; $display("FAIL fault_clear got st=%b err=%b exp st=00 err=0", state, err);
        end
      end
      if (i == 7) begin
        n_checks++;
        if (state !== 2'b11 || err !== 1'b1) begin
          n_fail++; $display("FAIL fault_clr_vs_bad got st=%b err=%b exp st=11 err=1", state, err);
        end
      end
    end
    // clr_err outside FAULT: model expects no effect
    step(c_C);
    got = outs(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL clr_outside_fault got=%h exp=%h", got, exp); end
  endtask

  task automatic test_gaps();
    logic [5:0]  seq[9];
    logic [21:0] got, exp;
    seq = '{c_M, c_I, c_M, c_I, c_I, c_M, c_I, c_I, c_M};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i]);
      got = outs(); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL gaps[%0d] got=%h exp=%h", i, got, exp); end
    end
    n_checks++;
    if (state !== 2'b10 || lock_pulse !== 1'b1 || match_cnt !== 8'd4) begin
      n_fail++; $display("FAIL gaps_lock got st=%b lp=%b mc=%0d exp st=10 lp=1 mc=4", state, lock_pulse, match_cnt);
    end
  endtask

  task automatic test_saturation_reset();
    logic [21:0] got, exp;
    int          bad_cnt;
    do_reset();
    bad_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step(c_M);
      got = outs(); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fail++; bad_cnt++;
        if (bad_cnt < 5) $display("FAIL sat[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    n_checks++;
    if (match_cnt !== 8'd255 || state !== 2'b10) begin
      n_fail++; $display("FAIL sat_final got mc=%0d st=%b exp mc=255 st=10", match_cnt, state);
    end
    // Asynchronous reset between edges must clear outputs without a clock.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 22'd0) begin
      n_fail++; $display("FAIL async_reset got=%h exp=%h", outs(), 22'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(c_M);
    got = outs(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL post_reset_sample got=%h exp=%h", got, exp); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_acquire();
    test_broken_run();
    test_lock_loss();
    test_fault();
    test_gaps();
    test_saturation_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
